// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: hunts the word boundary with a bit-slip window keyed on
// control tokens, then decodes aligned words into pixel data or control bits.
//
// state    | meaning
// S_SEARCH | hunting: count non-token words at this offset, slip when exhausted
// S_VERIFY | token seen: require a run of consecutive tokens before trusting it
// S_LOCKED | aligned: decode words, drop lock after a long gap without tokens
module tmds_channel_decoder #(
  parameter int SEARCH_WORDS = 1024,
  parameter int LOCK_COUNT   = 16,
  parameter int TIMEOUT_W    = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] raw,
  input  logic       raw_valid,
  output logic [7:0] data,
  output logic       de,
  output logic [1:0] ctrl,
  output logic       out_valid,
  output logic       locked,
  output logic [3:0] align_offset
);

  localparam int MISS_W = (SEARCH_WORDS > 1) ? $clog2(SEARCH_WORDS) : 1;
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [MISS_W-1:0]    MISS_LAST = MISS_W'(SEARCH_WORDS - 1);
  localparam logic [RUN_W-1:0]     RUN_LOCK  = RUN_W'(LOCK_COUNT);
  // timeout fires when the counter would reach all-ones
  localparam logic [TIMEOUT_W-1:0] TMO_PRE   = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [9:0]           prev_q, prev_d;
  logic [3:0]           align_q, align_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [7:0]           data_q, data_d;
  logic                 de_q, de_d;
  logic [1:0]           ctrl_q, ctrl_d;
  logic                 out_valid_q, out_valid_d;
  logic                 locked_q, locked_d;

  logic [9:0] win;
  logic       is_tok;
  logic [1:0] tok_ctrl;
  logic [7:0] win_d;
  logic [7:0] win_data;

  // extract the 10-bit window at the current offset and decode it both ways
  always_comb begin
    win      = 10'({raw, prev_q} >> align_q);
    is_tok   = 1'b1;
    tok_ctrl = 2'b00;
    case (win)
      10'b1101010100: tok_ctrl = 2'b00;
      10'b0010101011: tok_ctrl = 2'b01;
      10'b0101010100: tok_ctrl = 2'b10;
      10'b1010101011: tok_ctrl = 2'b11;
      default:        is_tok   = 1'b0;
    endcase
    win_d       = win[9] ? ~win[7:0] : win[7:0];
    win_data    = 8'h00;
    win_data[0] = win_d[0];
    for (int i = 1; i < 8; i++) begin
      win_data[i] = win[8] ? (win_d[i] ^ win_d[i-1]) : ~(win_d[i] ^ win_d[i-1]);
    end
  end

  // alignment FSM next state, counters and decoded outputs
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    align_d     = align_q;
    miss_d      = miss_q;
    run_d       = run_q;
    tmo_d       = tmo_q;
    data_d      = data_q;
    de_d        = de_q;
    ctrl_d      = ctrl_q;
    out_valid_d = 1'b0;
    locked_d    = locked_q;
    if (raw_valid) begin
      prev_d      = raw;
      out_valid_d = 1'b1;
      case (state_q)
        S_SEARCH: begin
          if (is_tok) begin
            state_d = (LOCK_COUNT <= 1) ? S_LOCKED : S_VERIFY;
            run_d   = RUN_W'(1);
            miss_d  = '0;
            tmo_d   = '0;
          end else if (miss_q == MISS_LAST) begin
            miss_d  = '0;
            align_d = (align_q == 4'd9) ? 4'd0 : align_q + 4'd1;
          end else begin
            miss_d  = miss_q + MISS_W'(1);
          end
        end
        S_VERIFY: begin
          if (is_tok) begin
            run_d = run_q + RUN_W'(1);
            if (run_d == RUN_LOCK) begin
              state_d = S_LOCKED;
              tmo_d   = '0;
            end
          end else begin
            state_d = S_SEARCH;
            miss_d  = '0;
          end
        end
        S_LOCKED: begin
          if (is_tok) begin
            tmo_d = '0;
          end else begin
            tmo_d = tmo_q + TIMEOUT_W'(1);
            if (tmo_q == TMO_PRE) begin
              state_d = S_SEARCH;
              miss_d  = '0;
            end
          end
        end
        default: state_d = S_SEARCH;
      endcase
      // output follows the state this word leaves us in
      if (state_d == S_LOCKED) begin
        if (is_tok) begin
          de_d   = 1'b0;
          data_d = 8'h00;
          ctrl_d = tok_ctrl;
        end else begin
          de_d   = 1'b1;
          data_d = win_data;
        end
      end else begin
        de_d   = 1'b0;
        data_d = 8'h00;
      end
      locked_d = (state_d == S_LOCKED);
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SEARCH;
      prev_q      <= '0;
      align_q     <= '0;
      miss_q      <= '0;
      run_q       <= '0;
      tmo_q       <= '0;
      data_q      <= '0;
      de_q        <= 1'b0;
      ctrl_q      <= 2'b00;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      align_q     <= align_d;
      miss_q      <= miss_d;
      run_q       <= run_d;
      tmo_q       <= tmo_d;
      data_q      <= data_d;
      de_q        <= de_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      locked_q    <= locked_d;
    end
  end

  assign data         = data_q;
  assign de           = de_q;
  assign ctrl         = ctrl_q;
  assign out_valid    = out_valid_q;
  assign locked       = locked_q;
  assign align_offset = align_q;

endmodule
